// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake, flush, illegal detection and load-use interlock.
// Optional RV32M decode is enabled by defining DECODE_RV32M_EN.
module decode_stage #(
  parameter int XLEN           = 32,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_alumux1,
  output logic            out_alumux2,
  output logic [4:0]      out_aluop,
  output logic [2:0]      out_funct3,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_reg_wr,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLT  = 5'd5;
  localparam logic [4:0] ALU_SLTU = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SRA  = 5'd9;
`ifdef DECODE_RV32M_EN
  localparam logic [4:0] ALU_MUL  = 5'd10;
`endif

  localparam int         HZ_INIT_I = (LOAD_USE_STALL > 0) ? LOAD_USE_STALL - 1 : 0;
  localparam logic [1:0] HZ_INIT   = HZ_INIT_I[1:0];

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_u;

  logic [XLEN-1:0] d_imm;
  logic [4:0]      d_rs1;
  logic [4:0]      d_rs2;
  logic [4:0]      d_rd;
  logic            d_alumux1;
  logic            d_alumux2;
  logic [4:0]      d_aluop;
  logic            d_mem_rd;
  logic            d_mem_wr;
  logic            d_branch;
  logic            d_jump;
  logic            d_reg_wr;
  logic            d_illegal;
  logic            uses_rs1;
  logic            uses_rs2;

  logic [1:0] hz_cnt;
  logic [4:0] ld_rd;
  logic       hz_out;
  logic       hz_ld;
  logic       hazard;
  logic       accept;
  logic       load_beat;

  function automatic logic [4:0] base_op(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
  assign imm_s = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};

  // The opcode compare includes instr[1:0], so compressed encodings fall into the illegal default.
  always_comb begin
    d_imm     = '0;
    d_rs1     = in_instr[19:15];
    d_rs2     = in_instr[24:20];
    d_rd      = in_instr[11:7];
    d_alumux1 = 1'b0;
    d_alumux2 = 1'b1;
    d_aluop   = ALU_ADD;
    d_mem_rd  = 1'b0;
    d_mem_wr  = 1'b0;
    d_branch  = 1'b0;
    d_jump    = 1'b0;
    d_reg_wr  = 1'b0;
    d_illegal = 1'b0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        d_imm    = imm_i;
        d_mem_rd = 1'b1;
        d_reg_wr = 1'b1;
      end
      OPC_STORE: begin
        d_imm    = imm_s;
        d_rd     = '0;
        d_mem_wr = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        d_imm     = imm_b;
        d_rd      = '0;
        d_alumux2 = 1'b0;
        d_branch  = 1'b1;
        uses_rs2  = 1'b1;
      end
      OPC_JAL: begin
        d_imm     = imm_j;
        d_alumux1 = 1'b1;
        d_jump    = 1'b1;
        d_reg_wr  = 1'b1;
        uses_rs1  = 1'b0;
      end
      OPC_JALR: begin
        d_imm    = imm_i;
        d_jump   = 1'b1;
        d_reg_wr = 1'b1;
      end
      OPC_OPIMM: begin
        d_imm    = imm_i;
        d_aluop  = base_op(funct3, (funct3 == 3'b101) & in_instr[30]);
        d_reg_wr = 1'b1;
      end
      OPC_OP: begin
        d_alumux2 = 1'b0;
        d_reg_wr  = 1'b1;
        uses_rs2  = 1'b1;
        case (funct7)
          7'b0000000: d_aluop = base_op(funct3, 1'b0);
          7'b0100000: begin
            if (funct3 == 3'b000 || funct3 == 3'b101) d_aluop = base_op(funct3, 1'b1);
            else                                      d_illegal = 1'b1;
          end
`ifdef DECODE_RV32M_EN
          7'b0000001: d_aluop = ALU_MUL + {2'b00, funct3};
`endif
          default:    d_illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        d_imm    = imm_u;
        d_rs1    = '0;
        d_reg_wr = 1'b1;
        uses_rs1 = 1'b0;
      end
      OPC_AUIPC: begin
        d_imm     = imm_u;
        d_alumux1 = 1'b1;
        d_reg_wr  = 1'b1;
        uses_rs1  = 1'b0;
      end
      default: d_illegal = 1'b1;
    endcase
    // Illegal bundles still flow downstream but must have no architectural side effects.
    if (d_illegal) begin
      d_imm     = '0;
      d_rd      = '0;
      d_alumux1 = 1'b0;
      d_alumux2 = 1'b0;
      d_aluop   = ALU_ADD;
      d_mem_rd  = 1'b0;
      d_mem_wr  = 1'b0;
      d_branch  = 1'b0;
      d_jump    = 1'b0;
      d_reg_wr  = 1'b0;
    end
  end

  // hz_out covers a load still sitting in the output register; hz_ld covers the idle window after it left.
  always_comb begin
    hz_out = 1'b0;
    hz_ld  = 1'b0;
    if (LOAD_USE_STALL > 0) begin
      hz_out = in_valid & out_valid & out_mem_rd & (out_rd != 5'd0) &
               ((uses_rs1 & (d_rs1 == out_rd)) | (uses_rs2 & (d_rs2 == out_rd)));
      hz_ld  = in_valid & (hz_cnt != 2'd0) & (ld_rd != 5'd0) &
               ((uses_rs1 & (d_rs1 == ld_rd)) | (uses_rs2 & (d_rs2 == ld_rd)));
    end
  end

  assign hazard    = hz_out | hz_ld;
  assign in_ready  = rst_n & ~flush & ~hazard & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign load_beat = out_valid & out_ready & out_mem_rd & (out_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_imm     <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_alumux1 <= 1'b0;
      out_alumux2 <= 1'b0;
      out_aluop   <= '0;
      out_funct3  <= '0;
      out_mem_rd  <= 1'b0;
      out_mem_wr  <= 1'b0;
      out_branch  <= 1'b0;
      out_jump    <= 1'b0;
      out_reg_wr  <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_imm     <= d_imm;
      out_rs1     <= d_rs1;
      out_rs2     <= d_rs2;
      out_rd      <= d_rd;
      out_alumux1 <= d_alumux1;
      out_alumux2 <= d_alumux2;
      out_aluop   <= d_aluop;
      out_funct3  <= funct3;
      out_mem_rd  <= d_mem_rd;
      out_mem_wr  <= d_mem_wr;
      out_branch  <= d_branch;
      out_jump    <= d_jump;
      out_reg_wr  <= d_reg_wr;
      out_illegal <= d_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      hz_cnt <= 2'd0;
      ld_rd  <= 5'd0;
    end else if ((LOAD_USE_STALL > 0) && load_beat) begin
      hz_cnt <= HZ_INIT;
      ld_rd  <= out_rd;
    end else if (hz_cnt != 2'd0) begin
      hz_cnt <= hz_cnt - 2'd1;
    end
  end

endmodule
